// File: rtl/xor_cipher_pkg.sv
// rtl/xor_cipher_pkg.sv - shared types and helpers for the XOR stream cipher
// Purpose: FSM state encoding, keystream rotate helper and the ROT legality check.
// Ports: none (package).
package xor_cipher_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widest word the rotate helper handles; callers cast to/from their own width.
  localparam int MAX_W = 64;

  // Legal keystream rotate amounts are 1..width-1 (0 or width would leave the
  // keystream constant across a burst).
  function automatic bit rot_is_legal(input int rot, input int width);
    return (width >= 2) && (width <= MAX_W) && (rot >= 1) && (rot <= width - 1);
  endfunction

  // Left-rotate the low `width` bits of `word` by `amt`; bits above `width` read as 0.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] word,
                                             input int amt,
                                             input int width);
    logic [MAX_W-1:0] r;
    int a;
    r = '0;
    a = amt % width;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) begin
        r[(i + a) % width] = word[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/xor_stream_cipher_if.sv
// rtl/xor_stream_cipher_if.sv - control and stream handshake bundle for the cipher
// Purpose: groups burst control, input stream, output stream and status signals.
// Ports (by modport direction, slave = cipher side):
//   start/key_in/len_in      burst control, driven by master
//   in_valid/data_in         input stream, driven by master; in_ready back
//   out_ready                output stream sink ready, driven by master
//   out_valid/data_out       output stream, driven by slave
//   busy/done                status, driven by slave
interface xor_stream_cipher_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) ();

  logic              start;
  logic [DATA_W-1:0] key_in;
  logic [LEN_W-1:0]  len_in;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              busy;
  logic              done;

  modport master (
    output start, key_in, len_in, in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy, done
  );

  modport slave (
    input  start, key_in, len_in, in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, busy, done
  );

endinterface

// File: rtl/xor_keystream_gen.sv
// rtl/xor_keystream_gen.sv - keystream register with load and rotate-advance
// Purpose: holds the running keystream word for the current burst.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (keystream -> 0)
//   load_i       load key_i (takes priority over advance_i)
//   key_i        initial keystream word
//   advance_i    rotate the keystream left by ROT
//   ks_o         current keystream word
module xor_keystream_gen
  import xor_cipher_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ROT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] key_i,
  input  logic              advance_i,
  output logic [DATA_W-1:0] ks_o
);

  logic [DATA_W-1:0] ks_q;
  logic [DATA_W-1:0] ks_d;

  always_comb begin
    ks_d = ks_q;
    if (load_i) begin
      ks_d = key_i;
    end else if (advance_i) begin
      ks_d = DATA_W'(rotl(MAX_W'(ks_q), ROT, DATA_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_q <= '0;
    end else begin
      ks_q <= ks_d;
    end
  end

  assign ks_o = ks_q;

endmodule

// File: rtl/xor_stream_cipher.sv
// rtl/xor_stream_cipher.sv - multi-word XOR stream cipher with rotating keystream
// Purpose: on start, latches key and burst length, then XORs len words with a
//          keystream that rotates left by ROT after every accepted word.
//          Symmetric: the same block encrypts and decrypts.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  start/key_in/len_in, in_valid/in_ready/data_in,
//                out_valid/out_ready/data_out, busy, done
module xor_stream_cipher
  import xor_cipher_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8,
  parameter int ROT    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  xor_stream_cipher_if.slave bus
);

  if (!rot_is_legal(ROT, DATA_W)) begin : g_rot_illegal
    $error("xor_stream_cipher: ROT must be in 1..DATA_W-1");
  end

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  in_cnt_q, in_cnt_d;
  logic [LEN_W-1:0]  out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              out_valid_q, out_valid_d;

  logic              ks_load;
  logic              ks_adv;
  logic [DATA_W-1:0] ks;
  logic              in_ready_c;
  logic              in_fire;
  logic              out_fire;
  logic              last_out;

  xor_keystream_gen #(
    .DATA_W (DATA_W),
    .ROT    (ROT)
  ) u_ks (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (ks_load),
    .key_i     (bus.key_in),
    .advance_i (ks_adv),
    .ks_o      (ks)
  );

  // Compare one bit wider so len = 2^LEN_W-1 never wraps.
  assign last_out = ({1'b0, out_cnt_q} + (LEN_W+1)'(1)) == {1'b0, len_q};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    ks_load     = 1'b0;
    ks_adv      = 1'b0;
    in_ready_c  = 1'b0;
    in_fire     = 1'b0;
    out_fire    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ks_load   = 1'b1;
          len_d     = bus.len_in;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = (bus.len_in == '0) ? DONE : RUN;
        end
      end

      RUN: begin
        // Accept a new word only if the output slot is free or draining this cycle.
        in_ready_c = (in_cnt_q < len_q) && (!out_valid_q || bus.out_ready);
        in_fire    = bus.in_valid && in_ready_c;
        out_fire   = out_valid_q && bus.out_ready;

        if (in_fire) begin
          data_out_d  = bus.data_in ^ ks;
          out_valid_d = 1'b1;
          ks_adv      = 1'b1;
          in_cnt_d    = in_cnt_q + 1'b1;
        end else if (out_fire) begin
          out_valid_d = 1'b0;
        end

        if (out_fire) begin
          out_cnt_d = out_cnt_q + 1'b1;
          if (last_out) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule
